miriscv_trap_ctrl: RTL and testbench

Machine-mode trap controller for the miriscv core. It owns the trap CSRs (mstatus, misa, mie, mip, mtvec, mepc, mcause, mtval and the ID registers) and serves the CSR instruction port. It arbitrates synchronous exceptions against the three machine interrupts, sequences trap entry as a flush-then-redirect handshake with the pipeline, and executes mret.

---
 rtl/miriscv_trap_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_miriscv_trap_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_trap_ctrl.sv
// Machine-mode trap controller for miriscv: owns the trap CSRs, serves the CSR port,
// arbitrates exceptions vs. interrupts, sequences flush-then-redirect trap entry and mret.
module miriscv_trap_ctrl #(
   parameter int unsigned MXLEN            = 32,
   parameter logic [31:0] MTVEC_BASE_RESET = 32'h0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             csr_req_i,
   input  logic [1:0]       csr_op_i,
   input  logic [11:0]      csr_addr_i,
   input  logic [MXLEN-1:0] csr_wdata_i,
   output logic [MXLEN-1:0] csr_rdata_o,
   output logic             csr_illegal_o,
   input  logic             exc_valid_i,
   input  logic [3:0]       exc_code_i,
   input  logic [MXLEN-1:0] exc_pc_i,
   input  logic [MXLEN-1:0] exc_tval_i,
   input  logic             irq_allow_i,
   input  logic [MXLEN-1:0] irq_pc_i,
   input  logic             irq_sw_i,
   input  logic             irq_timer_i,
   input  logic             irq_ext_i,
   input  logic             mret_i,
   output logic             busy_o,
   output logic             flush_o,
   output logic             pc_set_o,
   output logic [MXLEN-1:0] pc_target_o
);

   localparam int unsigned CSR_AW = 12;
   localparam int unsigned CODE_W = 4;
   localparam int unsigned OP_W   = 2;

   localparam logic [CSR_AW-1:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [CSR_AW-1:0] ADDR_MISA      = 12'h301;
   localparam logic [CSR_AW-1:0] ADDR_MIE       = 12'h304;
   localparam logic [CSR_AW-1:0] ADDR_MTVEC     = 12'h305;
   localparam logic [CSR_AW-1:0] ADDR_MEPC      = 12'h341;
   localparam logic [CSR_AW-1:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [CSR_AW-1:0] ADDR_MTVAL     = 12'h343;
   localparam logic [CSR_AW-1:0] ADDR_MIP       = 12'h344;
   localparam logic [CSR_AW-1:0] ADDR_MVENDORID = 12'hF11;
   localparam logic [CSR_AW-1:0] ADDR_MARCHID   = 12'hF12;
   localparam logic [CSR_AW-1:0] ADDR_MIMPID    = 12'hF13;

   localparam logic [OP_W-1:0] OP_RW  = 2'd0;
   localparam logic [OP_W-1:0] OP_RS  = 2'd1;
   localparam logic [OP_W-1:0] OP_RC  = 2'd2;
   localparam logic [OP_W-1:0] OP_ILL = 2'd3;

   localparam logic [CODE_W-1:0] CODE_MSI = 4'd3;
   localparam logic [CODE_W-1:0] CODE_MTI = 4'd7;
   localparam logic [CODE_W-1:0] CODE_MEI = 4'd11;

   localparam logic [MXLEN-1:0] MISA_VAL    = MXLEN'(32'h4000_0100);
   localparam logic [MXLEN-1:0] ALIGN4_MASK = ~MXLEN'(3);

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_JUMP} state_e;

   state_e state_q, state_d;

   logic             mstatus_mie_q, mstatus_mpie_q;
   logic             mie_msie_q, mie_mtie_q, mie_meie_q;
   logic [MXLEN-3:0] mtvec_base_q;
   logic [1:0]       mtvec_mode_q;
   logic [MXLEN-1:0] mepc_q, mcause_q, mtval_q;

   logic [MXLEN-1:0] mstatus_val, mie_val, mip_val, mtvec_val;
   logic             addr_known, addr_ro, csr_writes;
   logic [MXLEN-1:0] csr_wval;
   logic             idle, exc_take, irq_take, mret_take, csr_we;
   logic [2:0]       irq_pend;
   logic [CODE_W-1:0] irq_code;
   logic [MXLEN-1:0] trap_target;
   logic             busy_d, flush_d, pc_set_d;
   logic [MXLEN-1:0] pc_target_d;

   assign mstatus_val = MXLEN'({19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0});
   assign mie_val     = MXLEN'({20'b0, mie_meie_q, 3'b0, mie_mtie_q, 3'b0, mie_msie_q, 3'b0});
   assign mip_val     = MXLEN'({20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0});
   assign mtvec_val   = {mtvec_base_q, mtvec_mode_q};

   // CSR read mux and address classification
   always_comb begin
      csr_rdata_o = '0;
      addr_known  = 1'b1;
      addr_ro     = 1'b0;
      case (csr_addr_i)
         ADDR_MSTATUS: csr_rdata_o = mstatus_val;
         ADDR_MISA: begin
            csr_rdata_o = MISA_VAL;
            addr_ro     = 1'b1;
         end
         ADDR_MIE:    csr_rdata_o = mie_val;
         ADDR_MTVEC:  csr_rdata_o = mtvec_val;
         ADDR_MEPC:   csr_rdata_o = mepc_q;
         ADDR_MCAUSE: csr_rdata_o = mcause_q;
         ADDR_MTVAL:  csr_rdata_o = mtval_q;
         ADDR_MIP: begin
            csr_rdata_o = mip_val;
            addr_ro     = 1'b1;
         end
         ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: addr_ro = 1'b1;
         default: addr_known = 1'b0;
      endcase
   end

   // set/clear with a zero operand is a pure read
   assign csr_writes    = (csr_op_i == OP_RW) || (csr_wdata_i != '0);
   assign csr_illegal_o = csr_req_i & (~addr_known | (csr_op_i == OP_ILL) | (addr_ro & csr_writes));

   always_comb begin
      csr_wval = csr_rdata_o;
      case (csr_op_i)
         OP_RW:   csr_wval = csr_wdata_i;
         OP_RS:   csr_wval = csr_rdata_o | csr_wdata_i;
         OP_RC:   csr_wval = csr_rdata_o & ~csr_wdata_i;
         default: csr_wval = csr_rdata_o;
      endcase
   end

   // Trap arbitration: exception > interrupt > mret > CSR write
   assign idle     = (state_q == S_IDLE);
   assign irq_pend = {irq_ext_i & mie_meie_q, irq_sw_i & mie_msie_q, irq_timer_i & mie_mtie_q};
   assign exc_take  = idle & exc_valid_i;
   assign irq_take  = idle & ~exc_valid_i & irq_allow_i & mstatus_mie_q & (|irq_pend);
   assign mret_take = idle & ~exc_valid_i & ~irq_take & mret_i;
   assign csr_we    = idle & csr_req_i & ~csr_illegal_o & csr_writes &
                      ~exc_take & ~irq_take & ~mret_take;

   always_comb begin
      irq_code = CODE_MTI;
      if (irq_pend[2]) begin
         irq_code = CODE_MEI;
      end else if (irq_pend[1]) begin
         irq_code = CODE_MSI;
      end
   end

   // Vectored mode offsets only interrupts
   assign trap_target = {mtvec_base_q, 2'b00} +
                        (((mtvec_mode_q == 2'b01) && mcause_q[MXLEN-1]) ?
                         {mcause_q[MXLEN-3:0], 2'b00} : '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (exc_take || irq_take) state_d = S_FLUSH;
         S_FLUSH: state_d = S_JUMP;
         S_JUMP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d      = (state_d != S_IDLE);
      flush_d     = (state_d == S_FLUSH);
      pc_set_d    = (state_d == S_JUMP) || mret_take;
      pc_target_d = '0;
      if (state_d == S_JUMP) begin
         pc_target_d = trap_target;
      end else if (mret_take) begin
         pc_target_d = mepc_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         busy_o      <= 1'b0;
         flush_o     <= 1'b0;
         pc_set_o    <= 1'b0;
         pc_target_o <= '0;
      end else begin
         state_q     <= state_d;
         busy_o      <= busy_d;
         flush_o     <= flush_d;
         pc_set_o    <= pc_set_d;
         pc_target_o <= pc_target_d;
      end
   end

   // CSR state; update sources are mutually exclusive by construction
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b1;
         mie_msie_q     <= 1'b0;
         mie_mtie_q     <= 1'b0;
         mie_meie_q     <= 1'b0;
         mtvec_base_q   <= MTVEC_BASE_RESET[MXLEN-1:2];
         mtvec_mode_q   <= 2'b01;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
      end else if (exc_take) begin
         mcause_q <= MXLEN'(exc_code_i);
         mepc_q   <= exc_pc_i & ALIGN4_MASK;
         mtval_q  <= exc_tval_i;
      end else if (irq_take) begin
         mcause_q <= {1'b1, (MXLEN-1)'(irq_code)};
         mepc_q   <= irq_pc_i & ALIGN4_MASK;
         mtval_q  <= '0;
      end else if (state_q == S_FLUSH) begin
         mstatus_mpie_q <= mstatus_mie_q;
         mstatus_mie_q  <= 1'b0;
      end else if (mret_take) begin
         mstatus_mie_q  <= mstatus_mpie_q;
         mstatus_mpie_q <= 1'b1;
      end else if (csr_we) begin
         case (csr_addr_i)
            ADDR_MSTATUS: begin
               mstatus_mie_q  <= csr_wval[3];
               mstatus_mpie_q <= csr_wval[7];
            end
            ADDR_MIE: begin
               mie_msie_q <= csr_wval[3];
               mie_mtie_q <= csr_wval[7];
               mie_meie_q <= csr_wval[11];
            end
            ADDR_MTVEC: begin
               mtvec_base_q <= csr_wval[MXLEN-1:2];
               if (!csr_wval[1]) mtvec_mode_q <= csr_wval[1:0];
            end
            ADDR_MEPC:   mepc_q   <= csr_wval & ALIGN4_MASK;
            ADDR_MCAUSE: mcause_q <= csr_wval;
            ADDR_MTVAL:  mtval_q  <= csr_wval;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_miriscv_trap_ctrl.sv
// Scoreboarded bench for miriscv_trap_ctrl: directed trap/mret/reset scenarios, then
// randomized traffic against a CSR-level reference model.
module tb_miriscv_trap_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        csr_req_i;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;
   logic        exc_valid_i;
   logic [3:0]  exc_code_i;
   logic [31:0] exc_pc_i, exc_tval_i;
   logic        irq_allow_i;
   logic [31:0] irq_pc_i;
   logic        irq_sw_i, irq_timer_i, irq_ext_i;
   logic        mret_i;
   logic        busy_o, flush_o, pc_set_o;
   logic [31:0] pc_target_o;

   miriscv_trap_ctrl #(.MXLEN(32), .MTVEC_BASE_RESET(32'h0)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .csr_req_i(csr_req_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
      .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
      .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
      .exc_tval_i(exc_tval_i), .irq_allow_i(irq_allow_i), .irq_pc_i(irq_pc_i),
      .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
      .mret_i(mret_i), .busy_o(busy_o), .flush_o(flush_o), .pc_set_o(pc_set_o),
      .pc_target_o(pc_target_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed { logic is_pc; logic [31:0] tgt; } evt_t;
   evt_t exp_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: architectural CSR values plus remaining busy cycles
   bit          m_mie, m_mpie;
   logic [31:0] m_mie_reg, m_mtvec, m_mepc, m_mcause, m_mtval;
   int          busy_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mie = 1'b0; m_mpie = 1'b1; m_mie_reg = 32'h0; m_mtvec = 32'h1;
      m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0; busy_cnt = 0;
   endtask

   function automatic logic [31:0] m_mstatus();
      return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
   endfunction

   function automatic void model_read(input logic [11:0] a, output logic [31:0] v,
                                      output bit known, output bit ro);
      known = 1'b1; ro = 1'b0; v = 32'h0;
      case (a)
         12'h300: v = m_mstatus();
         12'h301: begin v = 32'h4000_0100; ro = 1'b1; end
         12'h304: v = m_mie_reg;
         12'h305: v = m_mtvec;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'h343: v = m_mtval;
         12'h344: begin
            v = (irq_ext_i ? 32'h800 : 32'h0) | (irq_timer_i ? 32'h80 : 32'h0) |
                (irq_sw_i ? 32'h8 : 32'h0);
            ro = 1'b1;
         end
         12'hF11, 12'hF12, 12'hF13: ro = 1'b1;
         default: known = 1'b0;
      endcase
   endfunction

   task automatic model_write(input logic [11:0] a, input logic [31:0] nv);
      case (a)
         12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
         12'h304: m_mie_reg = nv & 32'h888;
         12'h305: m_mtvec = {nv[31:2], (nv[1] ? m_mtvec[1:0] : nv[1:0])};
         12'h341: m_mepc = nv & ~32'h3;
         12'h342: m_mcause = nv;
         12'h343: m_mtval = nv;
         default: ;
      endcase
   endtask

   task automatic push_trap();
      logic [31:0] tgt;
      tgt = m_mtvec & ~32'h3;
      if (m_mtvec[1:0] == 2'b01 && m_mcause[31]) tgt = tgt + 32'(m_mcause[30:0]) * 4;
      exp_q.push_back('{1'b0, 32'h0});
      exp_q.push_back('{1'b1, tgt});
      busy_cnt = 2;
   endtask

   // One clock: check combinational/status outputs, advance the model, step to next negedge
   task automatic tick();
      logic [31:0] old, nv;
      bit known, ro, writes, ill;
      int code;
      #1;
      chk("busy", 32'(busy_o), 32'(busy_cnt > 0));
      model_read(csr_addr_i, old, known, ro);
      writes = (csr_op_i == 2'd0) || (csr_wdata_i != 32'h0);
      ill = csr_req_i && (!known || csr_op_i == 2'd3 || (ro && writes));
      chk("csr_illegal", 32'(csr_illegal_o), 32'(ill));
      if (csr_req_i) chk("csr_rdata", csr_rdata_o, old);
      if (busy_cnt > 0) begin
         if (busy_cnt == 2) begin m_mpie = m_mie; m_mie = 1'b0; end
         busy_cnt--;
      end else begin
         code = -1;
         if (irq_ext_i && m_mie_reg[11]) code = 11;
         else if (irq_sw_i && m_mie_reg[3]) code = 3;
         else if (irq_timer_i && m_mie_reg[7]) code = 7;
         if (exc_valid_i) begin
            m_mcause = 32'(exc_code_i); m_mepc = exc_pc_i & ~32'h3; m_mtval = exc_tval_i;
            push_trap();
         end else if (irq_allow_i && m_mie && code >= 0) begin
            m_mcause = 32'h8000_0000 | 32'(code); m_mepc = irq_pc_i & ~32'h3; m_mtval = 32'h0;
            push_trap();
         end else if (mret_i) begin
            exp_q.push_back('{1'b1, m_mepc});
            m_mie = m_mpie; m_mpie = 1'b1;
         end else if (csr_req_i && !ill && writes) begin
            case (csr_op_i)
               2'd0:    nv = csr_wdata_i;
               2'd1:    nv = old | csr_wdata_i;
               default: nv = old & ~csr_wdata_i;
            endcase
            model_write(csr_addr_i, nv);
         end
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic clear_inputs();
      csr_req_i = 1'b0; csr_op_i = 2'd0; csr_addr_i = 12'h0; csr_wdata_i = 32'h0;
      exc_valid_i = 1'b0; exc_code_i = 4'h0; exc_pc_i = 32'h0; exc_tval_i = 32'h0;
      irq_allow_i = 1'b0; irq_pc_i = 32'h0; irq_sw_i = 1'b0; irq_timer_i = 1'b0;
      irq_ext_i = 1'b0; mret_i = 1'b0;
   endtask

   task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
      csr_req_i = 1'b1; csr_addr_i = a; csr_op_i = op; csr_wdata_i = wd;
      tick();
      clear_inputs();
   endtask

   task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr_req_i = 1'b1; csr_addr_i = a; csr_op_i = 2'd1; csr_wdata_i = 32'h0;
      #1 chk(name, csr_rdata_o, exp);
      tick();
      clear_inputs();
   endtask

   task automatic trap_seq_chk(input string nm, input logic [31:0] tgt);
      #1;
      chk({nm, "_flush"}, 32'(flush_o), 32'd1);
      chk({nm, "_no_early_pc_set"}, 32'(pc_set_o), 32'd0);
      tick();
      #1;
      chk({nm, "_pc_set"}, 32'(pc_set_o), 32'd1);
      chk({nm, "_target"}, pc_target_o, tgt);
      tick();
   endtask

   function automatic logic [11:0] pick_addr(input int i);
      case (i)
         0: return 12'h300;  1: return 12'h301;  2: return 12'h304;  3: return 12'h305;
         4: return 12'h341;  5: return 12'h342;  6: return 12'h343;  7: return 12'h344;
         8: return 12'hF11;  9: return 12'hF12; 10: return 12'hF13;
         default: return 12'h7C0;
      endcase
   endfunction

   task automatic randomize_inputs();
      csr_req_i  = 1'($urandom_range(0, 1));
      csr_op_i   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      csr_addr_i = pick_addr(int'($urandom_range(0, 11)));
      case ($urandom_range(0, 3))
         0:       csr_wdata_i = 32'h0;
         1:       csr_wdata_i = $urandom & 32'h888;
         2:       csr_wdata_i = ($urandom & 32'h0000_FF00) | 32'($urandom_range(0, 3));
         default: csr_wdata_i = $urandom;
      endcase
      exc_valid_i = ($urandom_range(0, 19) == 0);
      exc_code_i  = 4'($urandom_range(0, 15));
      exc_pc_i    = $urandom & ~32'h3;
      exc_tval_i  = $urandom;
      irq_allow_i = 1'($urandom_range(0, 1));
      irq_pc_i    = $urandom & ~32'h3;
      irq_sw_i    = ($urandom_range(0, 3) == 0);
      irq_timer_i = ($urandom_range(0, 3) == 0);
      irq_ext_i   = ($urandom_range(0, 3) == 0);
      mret_i      = ($urandom_range(0, 14) == 0);
   endtask

   // Monitor: every flush/redirect pulse must match the next expected event
   initial begin
      evt_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_i) begin
            if (flush_o) begin
               if (exp_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_flush: got flush_o=1 expected no pulse at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("flush_order", 32'(e.is_pc), 32'd0);
               end
            end
            if (pc_set_o) begin
               if (exp_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_pc_set: got target 0x%08h expected no pulse at %0t",
                           pc_target_o, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("pc_set_order", 32'(e.is_pc), 32'd1);
                  chk("pc_target", pc_target_o, e.tgt);
               end
            end
         end
      end
   end

   initial begin
      clear_inputs();
      rst_i = 1'b1;
      model_reset();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Reset values
      #1;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_flush", 32'(flush_o), 32'd0);
      chk("rst_pc_set", 32'(pc_set_o), 32'd0);
      chk("rst_target", pc_target_o, 32'h0);
      rd_chk("rst_mstatus", 12'h300, 32'h0000_1880);
      rd_chk("rst_mtvec", 12'h305, 32'h0000_0001);
      rd_chk("rst_misa", 12'h301, 32'h4000_0100);
      rd_chk("rst_mvendorid", 12'hF11, 32'h0);

      // mtvec WARL mode and read-only write
      csr(12'h305, 2'd0, 32'h0000_1002);
      rd_chk("mtvec_mode_kept", 12'h305, 32'h0000_1001);
      csr(12'h305, 2'd0, 32'h0000_1000);
      rd_chk("mtvec_direct", 12'h305, 32'h0000_1000);
      csr_req_i = 1'b1; csr_addr_i = 12'hF12; csr_op_i = 2'd0; csr_wdata_i = 32'd5;
      #1 chk("marchid_write_illegal", 32'(csr_illegal_o), 32'd1);
      tick();
      clear_inputs();
      rd_chk("marchid_unchanged", 12'hF12, 32'h0);

      // Synchronous exception
      exc_valid_i = 1'b1; exc_code_i = 4'd2; exc_pc_i = 32'h80; exc_tval_i = 32'hDEAD;
      tick();
      clear_inputs();
      trap_seq_chk("exc", 32'h0000_1000);
      rd_chk("exc_mcause", 12'h342, 32'h2);
      rd_chk("exc_mepc", 12'h341, 32'h80);
      rd_chk("exc_mtval", 12'h343, 32'hDEAD);
      rd_chk("exc_mstatus", 12'h300, 32'h0000_1800);

      // Vectored interrupt, ext beats timer
      csr(12'h304, 2'd0, 32'h888);
      csr(12'h300, 2'd1, 32'h8);
      csr(12'h305, 2'd0, 32'h0000_1001);
      irq_timer_i = 1'b1; irq_ext_i = 1'b1; irq_allow_i = 1'b1; irq_pc_i = 32'h200;
      tick();
      clear_inputs();
      trap_seq_chk("irq_ext", 32'h0000_102C);
      rd_chk("irq_mcause", 12'h342, 32'h8000_000B);
      rd_chk("irq_mepc", 12'h341, 32'h200);
      rd_chk("irq_mtval", 12'h343, 32'h0);
      rd_chk("irq_mstatus", 12'h300, 32'h0000_1880);

      // mret back to the interrupted PC
      mret_i = 1'b1;
      tick();
      clear_inputs();
      #1;
      chk("mret_pc_set", 32'(pc_set_o), 32'd1);
      chk("mret_target", pc_target_o, 32'h200);
      tick();
      rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);

      // Timer alone
      irq_timer_i = 1'b1; irq_allow_i = 1'b1; irq_pc_i = 32'h240;
      tick();
      clear_inputs();
      trap_seq_chk("irq_timer", 32'h0000_101C);
      rd_chk("timer_mcause", 12'h342, 32'h8000_0007);

      // Exception and mret together: trap wins
      exc_valid_i = 1'b1; exc_code_i = 4'd5; exc_pc_i = 32'h300; exc_tval_i = 32'h55;
      mret_i = 1'b1;
      tick();
      clear_inputs();
      trap_seq_chk("exc_mret", 32'h0000_1000);
      rd_chk("exc_mret_mstatus", 12'h300, 32'h0000_1800);
      rd_chk("exc_mret_mepc", 12'h341, 32'h300);

      // Reset in FLUSH
      exc_valid_i = 1'b1; exc_code_i = 4'd1; exc_pc_i = 32'h400;
      tick();
      clear_inputs();
      rst_i = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_flush", 32'(flush_o), 32'd0);
      chk("midrst_pc_set", 32'(pc_set_o), 32'd0);
      chk("midrst_target", pc_target_o, 32'h0);
      exp_q.delete();
      model_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("no_pc_set_after_rst", 32'(pc_set_o), 32'd0);
         chk("no_flush_after_rst", 32'(flush_o), 32'd0);
         tick();
      end
      rd_chk("midrst_mtvec", 12'h305, 32'h1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         randomize_inputs();
         tick();
      end
      clear_inputs();
      repeat (4) tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
